// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// counter width.
package mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for several cycles and commit later.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns HI/LO and models fixed
// multi-cycle latency with a busy countdown.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d;
    logic [31:0]      lo_tmp_q, lo_tmp_d;
    logic             commit_q, commit_d;
    logic             busy_q, busy_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               s_ovf;
    logic [31:0]        sdiv_b, udiv_b;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;

    // Divisors are forced to 1 in the zero/overflow cases so the datapath never
    // evaluates an undefined divide; those cases are resolved explicitly.
    always_comb begin
        s_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        sdiv_b = ((B == 32'd0) || s_ovf) ? 32'd1 : B;
        udiv_b = (B == 32'd0) ? 32'd1 : B;

        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};

        quo_s = $signed(A) / $signed(sdiv_b);
        rem_s = $signed(A) % $signed(sdiv_b);
        if (s_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end

        quo_u = A / udiv_b;
        rem_u = A % udiv_b;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        commit_d = commit_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start && is_long_op(MDU_op)) begin
                    state_d  = ST_BUSY;
                    busy_d   = 1'b1;
                    commit_d = 1'b1;
                    case (MDU_op)
                        MDU_MULT: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        MDU_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        MDU_DIV: begin
                            hi_tmp_d = rem_s;
                            lo_tmp_d = quo_s;
                            commit_d = (B != 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                        default: begin
                            hi_tmp_d = rem_u;
                            lo_tmp_d = quo_u;
                            commit_d = (B != 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                    endcase
                end else if (start && (MDU_op == MDU_MTHI)) begin
                    hi_d = A;
                end else if (start && (MDU_op == MDU_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                // Any start while busy is dropped; only the countdown advances.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (commit_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            commit_q <= commit_d;
            busy_q   <= busy_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases from the test plan followed by
// randomized traffic, compared against an arithmetic reference model.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;

    int compared;
    int mismatched;

    // Reference state: architectural HI/LO, cycles still busy, pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_ok;
    int          m_left;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDU_op (MDU_op),
        .A      (A),
        .B      (B),
        .HI     (HI),
        .LO     (LO),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural result of a long op, using plain integer arithmetic.
    task automatic modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo, output logic ok);
        logic [63:0] p;
        int sa, sb;
        hi = 32'd0;
        lo = 32'd0;
        ok = 1'b1;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: begin
                p  = longint'(sa) * longint'(sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                p  = 64'(a) * 64'(b);
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                if (b == 32'd0) ok = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    // Effect of one rising edge on the reference model.
    task automatic modelEdge(input logic r, input logic s, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_left = 0;
            p_ok = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (s) begin
            if (o <= 3'd3) begin
                modelResult(o, a, b, p_hi, p_lo, p_ok);
                m_left = (o <= 3'd1) ? MC : DC;
            end else if (o == 3'd4) m_hi = a;
            else if (o == 3'd5) m_lo = a;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
        reset  = r;
        start  = s;
        MDU_op = o;
        A      = a;
        B      = b;
        @(posedge clk);
        modelEdge(r, s, o, a, b);
        #1;
        checkOutput("hi", HI, m_hi);
        checkOutput("lo", LO, m_lo);
        checkOutput("busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b0, 1'b1, o, a, b);
        idle((o <= 3'd1) ? MC : DC);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; p_ok = 1'b0; m_left = 0;
        reset = 1'b1; start = 1'b0; MDU_op = 3'd0; A = 32'd0; B = 32'd0;

        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        idle(3);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        runOp(3'd0, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_hi", HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo", LO, 32'hFFFF_FFFA);

        runOp(3'd1, 32'hFFFF_FFFE, 32'd3);
        checkOutput("multu_hi", HI, 32'h0000_0002);
        checkOutput("multu_lo", LO, 32'hFFFF_FFFA);

        runOp(3'd2, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_hi", HI, 32'hFFFF_FFFF);
        checkOutput("div_lo", LO, 32'hFFFF_FFFD);

        runOp(3'd3, 32'd7, 32'd0);
        checkOutput("divu0_hi", HI, 32'hFFFF_FFFF);
        checkOutput("divu0_lo", LO, 32'hFFFF_FFFD);

        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("ovf_hi", HI, 32'd0);
        checkOutput("ovf_lo", LO, 32'h8000_0000);

        applyStimulus(1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'd0);
        checkOutput("mthi_hi", HI, 32'h1234_5678);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);

        // Second start mid-operation must be dropped.
        applyStimulus(1'b0, 1'b1, 3'd1, 32'd2, 32'd3);
        applyStimulus(1'b0, 1'b1, 3'd1, 32'd5, 32'd5);
        idle(MC - 1);
        checkOutput("ignore_lo", LO, 32'd6);
        checkOutput("ignore_hi", HI, 32'd0);

        // Reset on the third busy cycle aborts without a later commit.
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd9, 32'd9);
        idle(2);
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_lo", LO, 32'd0);
        idle(MC + 2);
        checkOutput("abort_nocommit", LO, 32'd0);

        // Reset beats a simultaneous start.
        applyStimulus(1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd1);
        checkOutput("rst_start_lo", LO, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic        r, s;
            logic [2:0]  o;
            logic [31:0] a, b;
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) != 0);
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 16));
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            applyStimulus(r, s, o, a, b);
        end
        idle(DC + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
